// File: rtl/mips_pkg.sv
// Shared definitions for the two-stage MIPS lab CPU: ALU operation codes,
// opcode/funct field values and the operand-source / write-back-select encodings.
// Imported by the execute-stage control decode, the ALU and the CPU top.
package mips_pkg;

    typedef enum logic [3:0] {
        AluAnd   = 4'd0,
        AluOr    = 4'd1,
        AluXor   = 4'd2,
        AluNor   = 4'd3,
        AluAdd   = 4'd4,
        AluSub   = 4'd5,
        AluMult  = 4'd6,
        AluMultu = 4'd7,
        AluSll   = 4'd8,
        AluSrl   = 4'd9,
        AluSra   = 4'd10,
        AluSlt   = 4'd11,
        AluSltu  = 4'd12
    } alu_op_e;

    // B operand source
    typedef enum logic [1:0] {
        SrcRt      = 2'b00,
        SrcSignImm = 2'b01,
        SrcZeroImm = 2'b10
    } alu_src_e;

    // Write-back source
    typedef enum logic [1:0] {
        RegSelAlu = 2'b00,
        RegSelHi  = 2'b01,
        RegSelLo  = 2'b10
    } regsel_e;

    // Opcodes
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpSltiu = 6'h0B;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpXori  = 6'h0E;
    localparam logic [5:0] OpLui   = 6'h0F;

    // R-type funct codes
    localparam logic [5:0] FnSll   = 6'h00;
    localparam logic [5:0] FnSrl   = 6'h02;
    localparam logic [5:0] FnSra   = 6'h03;
    localparam logic [5:0] FnMfhi  = 6'h10;
    localparam logic [5:0] FnMflo  = 6'h12;
    localparam logic [5:0] FnMult  = 6'h18;
    localparam logic [5:0] FnMultu = 6'h19;
    localparam logic [5:0] FnAdd   = 6'h20;
    localparam logic [5:0] FnAddu  = 6'h21;
    localparam logic [5:0] FnSub   = 6'h22;
    localparam logic [5:0] FnSubu  = 6'h23;
    localparam logic [5:0] FnAnd   = 6'h24;
    localparam logic [5:0] FnOr    = 6'h25;
    localparam logic [5:0] FnXor   = 6'h26;
    localparam logic [5:0] FnNor   = 6'h27;
    localparam logic [5:0] FnSlt   = 6'h2A;
    localparam logic [5:0] FnSltu  = 6'h2B;

    localparam logic [4:0] LuiShamt = 5'd16;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Execute-stage control unit for the two-stage MIPS lab CPU.
// Combinational decode of opcode/shamt/funct into ALU op, operand source,
// write-back select, register-write and GPIO enables, plus a sticky
// illegal-instruction flag.
//
// Build option: CTRL_MULT_EN -- when defined, mult/multu/mfhi/mflo decode;
// otherwise those funct codes are unknown instructions and enhilo_EX is 0.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset (clears illegal)
//   i_type              opcode, instr[31:26]
//   shamt               instr[10:6]
//   function_code       instr[5:0]
//   stall_FETCH         current EX instruction is squashed
//   alu_op              ALU operation (mips_pkg::alu_op_e)
//   shamt_EX            shift amount to ALU
//   enhilo_EX           write HI/LO
//   regsel_EX           write-back source: 00 ALU lo, 01 HI, 10 LO
//   regwrite_EX         regfile write enable
//   rdrt_EX             destination select: 0 rd, 1 rt
//   memwrite_EX         data memory write (no stores, always 0)
//   alu_src_EX          B operand: 00 rt, 01 sign-ext imm, 10 zero-ext imm
//   GPIO_OUT, GPIO_IN   gpio_out write enable, write-back from gpio_in
//   illegal             sticky unknown-instruction flag
module mips_ctrl_decode
    import mips_pkg::*;
#(
    parameter logic [5:0] GPIO_IN_FUNCT  = 6'h3E,
    parameter logic [5:0] GPIO_OUT_FUNCT = 6'h3F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] i_type,
    input  logic [4:0] shamt,
    input  logic [5:0] function_code,
    input  logic       stall_FETCH,
    output logic [3:0] alu_op,
    output logic [4:0] shamt_EX,
    output logic       enhilo_EX,
    output logic [1:0] regsel_EX,
    output logic       regwrite_EX,
    output logic       rdrt_EX,
    output logic       memwrite_EX,
    output logic [1:0] alu_src_EX,
    output logic       GPIO_OUT,
    output logic       GPIO_IN,
    output logic       illegal
);

    alu_op_e  alu;
    alu_src_e src;
    regsel_e  regsel;
    logic     regwrite;
    logic     gpio_out;
    logic     gpio_in;
    logic     known;
    logic     illegal_q;
`ifdef CTRL_MULT_EN
    logic     enhilo;
`endif

    // Unknown encodings leave every field at its default, so no separate
    // clean-up pass is needed once known drops.
    always_comb begin
        alu      = AluAdd;
        shamt_EX = 5'd0;
        src      = SrcRt;
        regsel   = RegSelAlu;
        regwrite = 1'b0;
        rdrt_EX  = 1'b0;
        gpio_out = 1'b0;
        gpio_in  = 1'b0;
        known    = 1'b1;
`ifdef CTRL_MULT_EN
        enhilo   = 1'b0;
`endif
        if (i_type == OpRtype) begin
            // GPIO funct codes are parameters, so they are matched ahead of the case.
            if (function_code == GPIO_IN_FUNCT) begin
                gpio_in  = 1'b1;
                regwrite = 1'b1;
            end else if (function_code == GPIO_OUT_FUNCT) begin
                gpio_out = 1'b1;
            end else begin
                case (function_code)
                    FnAdd, FnAddu: begin alu = AluAdd;  regwrite = 1'b1; end
                    FnSub, FnSubu: begin alu = AluSub;  regwrite = 1'b1; end
                    FnAnd:         begin alu = AluAnd;  regwrite = 1'b1; end
                    FnOr:          begin alu = AluOr;   regwrite = 1'b1; end
                    FnXor:         begin alu = AluXor;  regwrite = 1'b1; end
                    FnNor:         begin alu = AluNor;  regwrite = 1'b1; end
                    FnSlt:         begin alu = AluSlt;  regwrite = 1'b1; end
                    FnSltu:        begin alu = AluSltu; regwrite = 1'b1; end
                    FnSll: begin
                        alu      = AluSll;
                        shamt_EX = shamt;
                        regwrite = 1'b1;
                    end
                    FnSrl: begin
                        alu      = AluSrl;
                        shamt_EX = shamt;
                        regwrite = 1'b1;
                    end
                    FnSra: begin
                        alu      = AluSra;
                        shamt_EX = shamt;
                        regwrite = 1'b1;
                    end
`ifdef CTRL_MULT_EN
                    FnMult:  begin alu = AluMult;  enhilo = 1'b1; end
                    FnMultu: begin alu = AluMultu; enhilo = 1'b1; end
                    FnMfhi:  begin regsel = RegSelHi; regwrite = 1'b1; end
                    FnMflo:  begin regsel = RegSelLo; regwrite = 1'b1; end
`endif
                    default: known = 1'b0;
                endcase
            end
        end else begin
            rdrt_EX  = 1'b1;
            regwrite = 1'b1;
            case (i_type)
                OpAddi, OpAddiu: begin alu = AluAdd;  src = SrcSignImm; end
                OpSlti:          begin alu = AluSlt;  src = SrcSignImm; end
                OpSltiu:         begin alu = AluSltu; src = SrcSignImm; end
                OpAndi:          begin alu = AluAnd;  src = SrcZeroImm; end
                OpOri:           begin alu = AluOr;   src = SrcZeroImm; end
                OpXori:          begin alu = AluXor;  src = SrcZeroImm; end
                OpLui: begin
                    // lui = imm << 16 on the zero-extended B operand
                    alu      = AluSll;
                    src      = SrcZeroImm;
                    shamt_EX = LuiShamt;
                end
                default: begin
                    known    = 1'b0;
                    rdrt_EX  = 1'b0;
                    regwrite = 1'b0;
                end
            endcase
        end
    end

    assign alu_op      = alu;
    assign alu_src_EX  = src;
    assign regsel_EX   = regsel;
    assign memwrite_EX = 1'b0;

    // A squashed instruction must not change architectural state.
    assign regwrite_EX = regwrite & ~stall_FETCH;
    assign GPIO_OUT    = gpio_out & ~stall_FETCH;
    assign GPIO_IN     = gpio_in & ~stall_FETCH;
`ifdef CTRL_MULT_EN
    assign enhilo_EX   = enhilo & ~stall_FETCH;
`else
    assign enhilo_EX   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_q <= 1'b0;
        end else if (!known && !stall_FETCH) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;

endmodule

// File: tb/tb_mips_ctrl_decode.sv
// Scoreboard bench for mips_ctrl_decode: directed vectors push hand-computed
// expectations into a queue; a negedge monitor pops and compares.
module tb_mips_ctrl_decode;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] i_type = '0;
    logic [4:0] shamt = '0;
    logic [5:0] function_code = '0;
    logic       stall_FETCH = 1'b0;
    logic [3:0] alu_op;
    logic [4:0] shamt_EX;
    logic       enhilo_EX;
    logic [1:0] regsel_EX;
    logic       regwrite_EX;
    logic       rdrt_EX;
    logic       memwrite_EX;
    logic [1:0] alu_src_EX;
    logic       GPIO_OUT;
    logic       GPIO_IN;
    logic       illegal;

    mips_ctrl_decode dut (
        .clk          (clk),
        .rst          (rst),
        .i_type       (i_type),
        .shamt        (shamt),
        .function_code(function_code),
        .stall_FETCH  (stall_FETCH),
        .alu_op       (alu_op),
        .shamt_EX     (shamt_EX),
        .enhilo_EX    (enhilo_EX),
        .regsel_EX    (regsel_EX),
        .regwrite_EX  (regwrite_EX),
        .rdrt_EX      (rdrt_EX),
        .memwrite_EX  (memwrite_EX),
        .alu_src_EX   (alu_src_EX),
        .GPIO_OUT     (GPIO_OUT),
        .GPIO_IN      (GPIO_IN),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] alu;
        logic [4:0] sh;
        logic       enhilo;
        logic [1:0] regsel;
        logic       rw;
        logic       rdrt;
        logic       mw;
        logic [1:0] src;
        logic       gout;
        logic       gin;
        logic       ill;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    logic  ill_exp = 1'b0;

    function automatic exp_t mk(input int alu, input int sh, input bit enhilo, input int regsel,
                                input bit rw, input bit rdrt, input int src, input bit gout,
                                input bit gin);
        exp_t e;
        e.alu    = 4'(alu);
        e.sh     = 5'(sh);
        e.enhilo = enhilo;
        e.regsel = 2'(regsel);
        e.rw     = rw;
        e.rdrt   = rdrt;
        e.mw     = 1'b0;
        e.src    = 2'(src);
        e.gout   = gout;
        e.gin    = gin;
        e.ill    = 1'b0;
        return e;
    endfunction

    function automatic string fmt(input exp_t e);
        return $sformatf("alu=%0d sh=%0d hilo=%0b rsel=%0d rw=%0b rdrt=%0b mw=%0b src=%0d go=%0b gi=%0b ill=%0b",
                         e.alu, e.sh, e.enhilo, e.regsel, e.rw, e.rdrt, e.mw, e.src, e.gout,
                         e.gin, e.ill);
    endfunction

    // Monitor: outputs are stable half a cycle after the inputs change.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  want;
            exp_t  got;
            string nm;
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            got  = '{alu: alu_op, sh: shamt_EX, enhilo: enhilo_EX, regsel: regsel_EX,
                     rw: regwrite_EX, rdrt: rdrt_EX, mw: memwrite_EX, src: alu_src_EX,
                     gout: GPIO_OUT, gin: GPIO_IN, ill: illegal};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL %s: got {%s} want {%s}", nm, fmt(got), fmt(want));
            end
        end
    end

    // Holds one vector for exactly one clock; illegal latches on the edge after it.
    task automatic apply(input string nm, input logic [5:0] op, input logic [4:0] sa,
                         input logic [5:0] fn, input bit stall, input bit rst_low,
                         input exp_t e, input bit unknown);
        @(posedge clk);
        #1;
        i_type        = op;
        shamt         = sa;
        function_code = fn;
        stall_FETCH   = stall;
        if (rst_low) begin
            rst     = 1'b0;
            ill_exp = 1'b0;
        end
        e.ill = ill_exp;
        exp_q.push_back(e);
        name_q.push_back(nm);
        if (unknown && !stall) ill_exp = 1'b1;
        if (rst_low) begin
            @(negedge clk);
            #1 rst = 1'b1;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        apply("add_after_reset", 6'h00, 5'd0, 6'h20, 0, 0, mk(4, 0, 0, 0, 1, 0, 0, 0, 0), 0);
        apply("addu_shamt_ign",  6'h00, 5'd3, 6'h21, 0, 0, mk(4, 0, 0, 0, 1, 0, 0, 0, 0), 0);
        apply("lui",             6'h0F, 5'd7, 6'h15, 0, 0, mk(8, 16, 0, 0, 1, 1, 2, 0, 0), 0);
        apply("addi",            6'h08, 5'd0, 6'h00, 0, 0, mk(4, 0, 0, 0, 1, 1, 1, 0, 0), 0);
        apply("andi",            6'h0C, 5'd0, 6'h00, 0, 0, mk(0, 0, 0, 0, 1, 1, 2, 0, 0), 0);
        apply("slti",            6'h0A, 5'd0, 6'h00, 0, 0, mk(11, 0, 0, 0, 1, 1, 1, 0, 0), 0);
        apply("srl_5",           6'h00, 5'd5, 6'h02, 0, 0, mk(9, 5, 0, 0, 1, 0, 0, 0, 0), 0);
        apply("sra_31",          6'h00, 5'd31, 6'h03, 0, 0, mk(10, 31, 0, 0, 1, 0, 0, 0, 0), 0);
        apply("nor",             6'h00, 5'd0, 6'h27, 0, 0, mk(3, 0, 0, 0, 1, 0, 0, 0, 0), 0);
        apply("sltu",            6'h00, 5'd0, 6'h2B, 0, 0, mk(12, 0, 0, 0, 1, 0, 0, 0, 0), 0);
        apply("sub_stall",       6'h00, 5'd0, 6'h22, 1, 0, mk(5, 0, 0, 0, 0, 0, 0, 0, 0), 0);
        apply("gpio_out",        6'h00, 5'd0, 6'h3F, 0, 0, mk(4, 0, 0, 0, 0, 0, 0, 1, 0), 0);
        apply("gpio_in",         6'h00, 5'd0, 6'h3E, 0, 0, mk(4, 0, 0, 0, 1, 0, 0, 0, 1), 0);
        apply("gpio_out_stall",  6'h00, 5'd0, 6'h3F, 1, 0, mk(4, 0, 0, 0, 0, 0, 0, 0, 0), 0);
        apply("gpio_in_stall",   6'h00, 5'd0, 6'h3E, 1, 0, mk(4, 0, 0, 0, 0, 0, 0, 0, 0), 0);
        apply("lw_unknown_op",   6'h23, 5'd0, 6'h20, 0, 0, mk(4, 0, 0, 0, 0, 0, 0, 0, 0), 1);
        apply("illegal_set",     6'h00, 5'd0, 6'h24, 0, 0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0), 0);
        apply("illegal_held",    6'h00, 5'd0, 6'h25, 1, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0), 0);
        apply("rst_mid_cycle",   6'h00, 5'd0, 6'h26, 0, 1, mk(2, 0, 0, 0, 1, 0, 0, 0, 0), 0);
        apply("after_reset",     6'h0E, 5'd0, 6'h00, 0, 0, mk(2, 0, 0, 0, 1, 1, 2, 0, 0), 0);
        apply("unknown_stalled", 6'h3A, 5'd0, 6'h00, 1, 0, mk(4, 0, 0, 0, 0, 0, 0, 0, 0), 1);
        apply("stall_no_set",    6'h00, 5'd0, 6'h2A, 0, 0, mk(11, 0, 0, 0, 1, 0, 0, 0, 0), 0);
`ifdef CTRL_MULT_EN
        apply("mult",            6'h00, 5'd0, 6'h18, 0, 0, mk(6, 0, 1, 0, 0, 0, 0, 0, 0), 0);
        apply("mfhi",            6'h00, 5'd0, 6'h10, 0, 0, mk(4, 0, 0, 1, 1, 0, 0, 0, 0), 0);
        apply("mflo",            6'h00, 5'd0, 6'h12, 0, 0, mk(4, 0, 0, 2, 1, 0, 0, 0, 0), 0);
        apply("multu_stall",     6'h00, 5'd0, 6'h19, 1, 0, mk(7, 0, 0, 0, 0, 0, 0, 0, 0), 0);
`else
        apply("mult_disabled",   6'h00, 5'd0, 6'h18, 0, 0, mk(4, 0, 0, 0, 0, 0, 0, 0, 0), 1);
        apply("mfhi_disabled",   6'h00, 5'd0, 6'h10, 0, 0, mk(4, 0, 0, 0, 0, 0, 0, 0, 0), 1);
        apply("mflo_disabled",   6'h00, 5'd0, 6'h12, 0, 0, mk(4, 0, 0, 0, 0, 0, 0, 0, 0), 1);
        apply("multu_disabled",  6'h00, 5'd0, 6'h19, 1, 0, mk(4, 0, 0, 0, 0, 0, 0, 0, 0), 1);
`endif
        apply("nop_sll_r0",      6'h00, 5'd0, 6'h00, 0, 0, mk(8, 0, 0, 0, 1, 0, 0, 0, 0), 0);
        apply("unknown_funct",   6'h00, 5'd0, 6'h01, 0, 0, mk(4, 0, 0, 0, 0, 0, 0, 0, 0), 1);
        apply("xori_final",      6'h0E, 5'd0, 6'h00, 0, 0, mk(2, 0, 0, 0, 1, 1, 2, 0, 0), 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
